// File: rtl/seq_mul64_pkg.sv
// Shared definitions for the 64-bit sequential shift-add multiplier.
// Optional feature macro: LOGIC_LOCK_EN (adds the working_key port and key logic).
package seq_mul64_pkg;

    // Operand and result width.
    localparam int WIDTH = 64;

    // Number of shift-add steps in a full multiplication.
    localparam int ITERATIONS = 64;

    // Iteration counter width; counts 0 .. ITERATIONS-1.
    localparam int CNT_W = $clog2(ITERATIONS);

    // Key width and the default correct unlock key.
    localparam int KEY_W = 8;
    localparam logic [KEY_W-1:0] KEY_VALUE_DEFAULT = 8'hA5;

    // Handshake controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter value at which the final step is taken. A short run stops
    // one step early.
    function automatic logic [CNT_W-1:0] last_count(input logic short_run);
        if (short_run) begin
            return CNT_W'(ITERATIONS - 2);
        end
        return CNT_W'(ITERATIONS - 1);
    endfunction

endpackage : seq_mul64_pkg

// File: rtl/seq_mul64_dp.sv
// Shift-add datapath: operand registers, accumulator and iteration counter.
// The controller decides when to load and when to step; this block only
// reports when the step being taken is the last one.
// Optional feature macro: none here (key effects arrive as sub_mode/short_run).
module seq_mul64_dp
    import seq_mul64_pkg::*;
(
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             sub_mode,
    input  logic             short_run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last_step,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] addend;

    // Partial product for this step: the multiplicand gated by the
    // multiplier's current LSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // Accumulator value after the current step, modulo 2^WIDTH.
    always_comb begin
        acc_next = acc_reg + addend;
        if (sub_mode) begin
            acc_next = acc_reg - addend;
        end
    end

    // Final step is flagged combinationally so the controller can capture
    // acc_next on the same edge that the last step is taken.
    assign last_step = (cnt_reg == last_count(short_run));

    // Operand capture on load, otherwise one radix-2 step per enabled cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (load) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (step) begin
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            acc_reg    <= acc_next;
            cnt_reg    <= last_step ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule : seq_mul64_dp

// File: rtl/seq_mul64_hs.sv
// 64x64 -> low 64-bit sequential multiplier with an ap_ctrl_hs style
// responder handshake. Controller FSM and result register live here; the
// shift-add datapath is seq_mul64_dp.
// Optional feature macro: LOGIC_LOCK_EN adds working_key; a key that differs
// from KEY_VALUE corrupts the run length, add/subtract, return path and the
// low result bits.
module seq_mul64_hs
    import seq_mul64_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_VALUE = KEY_VALUE_DEFAULT
)
(
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ap_return
`ifdef LOGIC_LOCK_EN
    ,
    input  logic [KEY_W-1:0] working_key
`endif
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] ap_return_reg;
    logic [KEY_W-1:0] key_mismatch;
    logic [WIDTH-1:0] return_mask;
    logic             load;
    logic             step;
    logic             last_step;
    logic [WIDTH-1:0] acc_next;

    // Each set bit marks a key bit that disagrees with KEY_VALUE. Without
    // the lock the mismatch is constant zero and the key logic folds away.
`ifdef LOGIC_LOCK_EN
    assign key_mismatch = working_key ^ KEY_VALUE;
`else
    assign key_mismatch = KEY_VALUE ^ KEY_VALUE;
`endif

    // Upper mismatch bits perturb result bits 7:3.
    assign return_mask = {{(WIDTH-8){1'b0}}, key_mismatch[7:3], 3'b000};

    seq_mul64_dp u_dp (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .load      (load),
        .step      (step),
        .sub_mode  (key_mismatch[1]),
        .short_run (key_mismatch[0]),
        .a         (a),
        .b         (b),
        .last_step (last_step),
        .acc_next  (acc_next)
    );

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath control. ap_start is only looked at in IDLE,
    // so holding it through CALC and DONE has no effect.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ap_start) begin
                    load       = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = key_mismatch[2] ? ST_CALC : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Result register: loaded with the post-final-step accumulator on the
    // CALC -> DONE edge and held until the next completion.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_return_reg <= '0;
        end else if (state_reg == ST_CALC && last_step) begin
            ap_return_reg <= acc_next ^ return_mask;
        end
    end

    // Handshake outputs decoded from state; done and ready are the same pulse.
    always_comb begin
        ap_done  = (state_reg == ST_DONE);
        ap_ready = (state_reg == ST_DONE);
        ap_idle  = (state_reg == ST_IDLE) && !ap_start;
    end

    assign ap_return = ap_return_reg;

endmodule : seq_mul64_hs

// File: tb/tb_seq_mul64_hs.sv
// Self-checking bench for seq_mul64_hs. A timeline model (start accepted at
// edge N -> done after edge N+64, idle again after edge N+65, result = a*b)
// is checked every cycle, alongside directed literal expectations.
// Optional feature macro: LOGIC_LOCK_EN enables the key tests.
module tb_seq_mul64_hs;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] ap_return;
`ifdef LOGIC_LOCK_EN
    logic [7:0]  working_key;
`endif

    int checks = 0;
    int errors = 0;

    seq_mul64_hs dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .a         (a),
        .b         (b),
        .ap_return (ap_return)
`ifdef LOGIC_LOCK_EN
        ,
        .working_key (working_key)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural timeline model ----------------
    bit          model_en = 1'b1;
    bit          m_busy   = 1'b0;
    int          m_edge   = 0;
    int          m_acc_edge = 0;
    logic [63:0] m_pending = '0;
    logic [63:0] m_return  = '0;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_busy   = 1'b0;
            m_return = '0;
        end else begin
            m_edge++;
            if (!m_busy) begin
                if (ap_start) begin
                    m_busy     = 1'b1;
                    m_acc_edge = m_edge;
                    m_pending  = a * b;
                end
            end else begin
                if (m_edge == m_acc_edge + 64) m_return = m_pending;
                if (m_edge == m_acc_edge + 65) m_busy = 1'b0;
            end
        end
    end

    // Compare process: outputs checked mid-cycle against the model.
    always @(negedge ap_clk) begin
        if (model_en) begin
            logic exp_done;
            exp_done = ap_rst_n && m_busy && (m_edge == m_acc_edge + 64);
            chk("model_done",   64'(ap_done),  64'(exp_done));
            chk("model_ready",  64'(ap_ready), 64'(exp_done));
            chk("model_idle",   64'(ap_idle),  64'(!m_busy && !ap_start));
            chk("model_return", ap_return,     m_return);
        end
    end

    // ---------------- stimulus ----------------
    // Raises ap_start with the operands and waits for the done pulse.
    // edges = posedges since ap_start was raised when done is first seen
    // (acceptance edge + 64 CALC edges = 65). With scramble set, a, b and
    // ap_start are randomised after acceptance. With keep_start set, ap_start
    // stays high after the pulse.
    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_op,
                         input bit scramble, input bit keep_start,
                         output logic [63:0] res, output int edges);
        bit seen;
        seen  = 1'b0;
        res   = '0;
        edges = 0;
        @(posedge ap_clk); #2;
        a = ta; b = tb_op; ap_start = 1'b1;
        while (!seen && edges < 200) begin
            @(negedge ap_clk);
            edges++;
            if (ap_done) begin
                seen = 1'b1;
                res  = ap_return;
            end else if (scramble && edges >= 2) begin
                #3;
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                ap_start = 1'($urandom_range(0, 1));
            end
        end
        edges = edges - 1;
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
        @(posedge ap_clk); #2;
        if (!keep_start) ap_start = 1'b0;
    endtask

    initial begin
        logic [63:0] res;
        int          edges;
        logic [63:0] ra;
        logic [63:0] rb;
        int          k;
        int          done_cnt;

        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        a = '0;
        b = '0;
`ifdef LOGIC_LOCK_EN
        working_key = 8'hA5;
`endif
        repeat (3) @(posedge ap_clk);
        #2 ap_rst_n = 1'b1;

        // Idle after reset release.
        @(negedge ap_clk);
        chk("reset_done",   64'(ap_done),  64'(0));
        chk("reset_ready",  64'(ap_ready), 64'(0));
        chk("reset_idle",   64'(ap_idle),  64'(1));
        chk("reset_return", ap_return,     64'(0));

        // 3 * 5 with latency and idle-next-cycle check.
        do_op(64'd3, 64'd5, 1'b0, 1'b0, res, edges);
        $display("op a=3 b=5 -> %0d edges=%0d", res, edges);
        chk("mul_3x5", res, 64'd15);
        chk("latency_3x5", 64'(edges), 64'd65);
        @(negedge ap_clk);
        chk("idle_after_done", 64'(ap_idle), 64'(1));

        // Wrap-around.
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, res, edges);
        $display("op a=all-ones b=2 -> %h", res);
        chk("mul_wrap", res, 64'hFFFF_FFFF_FFFF_FFFE);

        // Reset after 30 CALC cycles: no done, result cleared, then 6*7.
        @(posedge ap_clk); #2;
        a = 64'd1000; b = 64'd77; ap_start = 1'b1;
        repeat (31) @(posedge ap_clk);
        #2 ap_rst_n = 1'b0; ap_start = 1'b0;
        @(negedge ap_clk);
        chk("midreset_return", ap_return,     64'(0));
        chk("midreset_done",   64'(ap_done),  64'(0));
        chk("midreset_idle",   64'(ap_idle),  64'(1));
        repeat (2) @(posedge ap_clk);
        #2 ap_rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge ap_clk);
            if (ap_done) done_cnt++;
        end
        chk("midreset_no_done", 64'(done_cnt), 64'(0));
        chk("midreset_idle_after", 64'(ap_idle), 64'(1));
        do_op(64'd6, 64'd7, 1'b0, 1'b0, res, edges);
        $display("op a=6 b=7 -> %0d", res);
        chk("mul_6x7", res, 64'd42);

        // Zero operands take the full latency.
        do_op(64'd12345, 64'd0, 1'b0, 1'b0, res, edges);
        $display("op a=12345 b=0 -> %0d edges=%0d", res, edges);
        chk("mul_b0", res, 64'd0);
        chk("latency_b0", 64'(edges), 64'd65);
        do_op(64'd0, 64'd7, 1'b0, 1'b0, res, edges);
        $display("op a=0 b=7 -> %0d", res);
        chk("mul_a0", res, 64'd0);

        // ap_start held through DONE: the next op starts on the following
        // edge, so the next done pulse is 66 cycles after the first.
        do_op(64'd9, 64'd11, 1'b0, 1'b1, res, edges);
        $display("op a=9 b=11 (start held) -> %0d", res);
        chk("mul_9x11", res, 64'd99);
        a = 64'd2; b = 64'd3;
        k = 0;
        res = '0;
        while (k < 200) begin
            @(negedge ap_clk);
            k++;
            if (k == 2) begin
                #3 ap_start = 1'b0;
            end
            if (ap_done) begin
                res = ap_return;
                break;
            end
        end
        $display("op a=2 b=3 (back-to-back) -> %0d gap=%0d", res, k);
        chk("b2b_gap", 64'(k), 64'd66);
        chk("mul_2x3", res, 64'd6);
        @(posedge ap_clk); #2;

        // Random operands, with inputs scrambled during CALC.
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 0) rb = 64'h8000_0000_0000_0001;
            if (i == 1) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            do_op(ra, rb, 1'b1, 1'b0, res, edges);
            $display("op a=%h b=%h -> %h", ra, rb, res);
            chk("mul_random", res, ra * rb);
            chk("latency_random", 64'(edges), 64'd65);
        end

`ifdef LOGIC_LOCK_EN
        // Correct key matches the unlocked behaviour.
        working_key = 8'hA5;
        do_op(64'd3, 64'd5, 1'b0, 1'b0, res, edges);
        $display("op key=a5 a=3 b=5 -> %0d", res);
        chk("lock_good_key", res, 64'd15);
        // Bit 0 wrong: only 63 steps, so the top multiplier bit is dropped.
        model_en = 1'b0;
        working_key = 8'hA4;
        do_op(64'd1, 64'h8000_0000_0000_0001, 1'b0, 1'b0, res, edges);
        $display("op key=a4 a=1 b=8000000000000001 -> %h", res);
        chk("lock_short_run", res, 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_mul64_hs

// File: doc/seq_mul64_hs.md
SEQ_MUL64_HS -- requirements
Module: seq_mul64_hs

Interface
REQ-001 SHALL have parameter: KEY_VALUE, default 8'hA5, correct unlock key (used only when LOGIC_LOCK_EN defined).
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port: ap_clk  input  1  rising-edge clock.
REQ-004 SHALL have port: ap_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: ap_start  input  1  initiator request, held high until ap_ready seen.
REQ-006 SHALL have port: ap_done  output  1  one-cycle result-valid pulse.
REQ-007 SHALL have port: ap_idle  output  1  high when in IDLE and ap_start low.
REQ-008 SHALL have port: ap_ready  output  1  one-cycle pulse, same cycle as ap_done.
REQ-009 SHALL have port: a  input  64  multiplicand, sampled at start.
REQ-010 SHALL have port: b  input  64  multiplier, sampled at start.
REQ-011 SHALL have port: ap_return  output  64  low 64 bits of unsigned a*b.
REQ-012 SHALL have port: working_key  input  8  lock key, present only when LOGIC_LOCK_EN defined.

Function
REQ-013 SHALL implement FSM IDLE, CALC, DONE as the responder side of the ap_ctrl_hs handshake.
REQ-014 IDLE: on ap_start=1 at a clock edge, SHALL capture a, b, clear accumulator and iteration counter, go to CALC.
REQ-015 CALC: SHALL perform one radix-2 shift-add step per cycle (LSB of multiplier register set -> acc += multiplicand register; multiplicand <<1; multiplier >>1), modulo 2^64.
REQ-016 CALC SHALL last exactly 64 cycles (6-bit counter 0..63; wrap at 63 -> DONE), regardless of operand values.
REQ-017 DONE: SHALL assert ap_done=1 and ap_ready=1 for exactly one cycle, then go to IDLE unconditionally; ap_start in DONE SHALL be ignored.
REQ-018 Latency: start sampled at edge N -> ap_done high during the cycle after edge N+64; next start accepted at edge N+66.
REQ-019 ap_return SHALL update only on entry to DONE and hold until the next DONE.
REQ-020 ap_start changes and a/b changes during CALC SHALL not affect the result.
REQ-021 ap_idle SHALL be low in CALC and DONE.

Reset
REQ-022 Reset assertion at any time, including mid-CALC, SHALL force IDLE, and clear ap_return, accumulator, counter and operand registers to 0 with no ap_done pulse.
REQ-023 After reset release with ap_start=0, ap_idle SHALL be 1 and ap_done/ap_ready SHALL be 0.

Configuration
REQ-024 With LOGIC_LOCK_EN defined, the working_key port and key logic SHALL exist; working_key==KEY_VALUE SHALL give results identical to the unlocked build.
REQ-025 Locked build, mismatched key bit 0: CALC SHALL run 63 cycles; bit 1: accumulator SHALL subtract instead of add; bit 2: DONE SHALL return to CALC instead of IDLE; bits 7:3: mismatch mask SHALL XOR into ap_return[7:3].
REQ-026 Without LOGIC_LOCK_EN, no working_key port SHALL exist and behaviour SHALL be REQ-013..023 only.

Structure
REQ-027 Package seq_mul64_pkg SHALL hold the state enum, the WIDTH=64 constant, iteration count 64 and the KEY_VALUE default.
REQ-028 The shift-add datapath (operand registers, accumulator, counter) SHALL be sub-module seq_mul64_dp; seq_mul64_hs keeps the FSM and handshake.

Verification
REQ-029 a=3, b=5, start held until ready -> ap_done one cycle at 65 cycles after start edge, ap_return=15, ap_idle=1 next cycle.
REQ-030 a=64'hFFFF_FFFF_FFFF_FFFF, b=2 -> ap_return=64'hFFFF_FFFF_FFFF_FFFE (wrap-around).
REQ-031 b=0 -> ap_return=0 after the full 64-cycle latency; a=0, b=7 -> 0.
REQ-032 Reset pulsed at cycle 30 of CALC -> no ap_done, ap_return=0, IDLE; new start with a=6, b=7 -> 42.
REQ-033 ap_start kept high through DONE -> exactly one ap_done pulse for that start; next operation begins from IDLE on the following edge.
REQ-034 LOGIC_LOCK_EN build: key 8'hA5, a=3, b=5 -> 15; key 8'hA4 (bit 0 wrong) -> result of only 63 steps, differs for b=64'h8000_0000_0000_0001 with a=1 (1, not 64'h8000_0000_0000_0001).
